rgb565_to_ycbcr: RTL
====================

RGB565_TO_YCBCR -- requirements
Module: rgb565_to_ycbcr

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset.
REQ-002 Port clk: input, 1 bit, pixel clock; all registers update on its rising edge.
REQ-003 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-004 Port pre_frame_vsync: input, 1 bit, frame sync, active-high, frame starts on its rising edge.
REQ-005 Port pre_frame_href: input, 1 bit, line valid.
REQ-006 Port pre_frame_de: input, 1 bit, pixel valid qualifier.
REQ-007 Ports img_red, img_green, img_blue: inputs, 5 / 6 / 5 bits, RGB565 pixel components.
REQ-008 Ports post_frame_vsync, post_frame_href, post_frame_de: outputs, 1 bit each, input syncs delayed to align with the output pixel.
REQ-009 Ports img_y, img_cb, img_cr: outputs, 8 bits each, converted pixel.
REQ-010 Port frame_pix_cnt: output, 20 bits, present only with YCBCR_PIXCNT_EN (see REQ-025).

Function
REQ-011 The block SHALL expand components by MSB replication: R8 = {R5, R5[4:2]}, G8 = {G6, G6[5:4]}, B8 = {B5, B5[4:2]}.
REQ-012 Stage 1 SHALL register the nine unsigned 16-bit products 77R8, 150G8, 29B8, 43R8, 85G8, 128B8, 128R8, 107G8 and 21B8.
REQ-013 Stage 2 SHALL register these sums:
- Ysum = 77R+150G+29B
- Cbsum = 128B-43R-85G+32768
- Crsum = 128R-107G-21B+32768
REQ-014 Stage 2 sums SHALL be 17 bits wide; the subtraction ordering SHALL keep every intermediate non-negative.
REQ-015 Stage 3 SHALL register img_y/img_cb/img_cr = sum[15:8] when stage-2 de = 1, else 8'd0.
REQ-016 Over the full 8-bit input range no sum SHALL exceed 65535, so no clamping logic is required.
REQ-017 Latency SHALL be exactly 3 clk cycles from an input pixel sample to its output pixel.
REQ-018 vsync, href and de SHALL each pass through a 3-stage register chain, so post_* sits on the same cycle as its pixel.
REQ-019 The pipeline SHALL have no stall and no back-pressure; a new pixel SHALL be accepted every cycle.
REQ-020 Back-to-back de pulses, isolated one-cycle de, and de low inside href SHALL all convert correctly and independently.
REQ-021 Pipeline contents SHALL not depend on sync state; only de gates the data outputs.

Reset
REQ-022 While rst_n = 0, every pipeline register and every output SHALL be 0, including post_* syncs, img_*, and frame_pix_cnt.
REQ-023 Reset asserted mid-frame SHALL discard in-flight pixels.
REQ-024 After reset release, the first valid output SHALL appear 3 cycles after the first de = 1 input; outputs SHALL stay 0 until then.

Configuration
REQ-025 With macro YCBCR_PIXCNT_EN defined, the block SHALL count output cycles with post_frame_de = 1 in a 20-bit counter.
REQ-026 Under YCBCR_PIXCNT_EN the counter SHALL saturate at 1048575 and SHALL clear on each rising edge of post_frame_vsync.
REQ-027 Under YCBCR_PIXCNT_EN, on that same rising edge frame_pix_cnt SHALL latch the pre-clear count; when a de cycle coincides with the edge, that pixel SHALL count into the new frame.
REQ-028 Without YCBCR_PIXCNT_EN, the frame_pix_cnt port and counter logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 White (31,63,31) with de = 1 at cycle N -> at N+3 Y=255, Cb=128, Cr=128, post_frame_de=1.
REQ-030 Black (0,0,0) -> Y=0, Cb=128, Cr=128; and with de = 0 at any pixel value -> Y=Cb=Cr=0.
REQ-031 Red (31,0,0) -> Y=76, Cb=85, Cr=255; green (0,63,0) -> Y=149, Cb=43, Cr=21; blue (0,0,31) -> Y=28, Cb=255, Cr=107.
REQ-032 Sync alignment: 1-cycle pulses on vsync, href and de at cycle N -> each post_* is high exactly at cycle N+3; a continuous 640-pixel line gives 640 consecutive output pixels in order.
REQ-033 Reset: rst_n pulsed low for 1 cycle mid-line -> all outputs 0 immediately; the next de at cycle M gives output at M+3.
REQ-034 With YCBCR_PIXCNT_EN: frame of 480 lines x 640 de pixels, then a vsync rising edge -> frame_pix_cnt = 307200.

Source files
------------

// File: rtl/rgb565_to_ycbcr.sv
// rgb565_to_ycbcr: 3-stage RGB565 -> YCbCr (BT.601 8-bit) converter; define YCBCR_PIXCNT_EN for the per-frame pixel counter
module rgb565_to_ycbcr (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pre_frame_vsync,
   input  logic        pre_frame_href,
   input  logic        pre_frame_de,
   input  logic [4:0]  img_red,
   input  logic [5:0]  img_green,
   input  logic [4:0]  img_blue,
   output logic        post_frame_vsync,
   output logic        post_frame_href,
   output logic        post_frame_de,
   output logic [7:0]  img_y,
   output logic [7:0]  img_cb,
   output logic [7:0]  img_cr
`ifdef YCBCR_PIXCNT_EN
   ,
   output logic [19:0] frame_pix_cnt
`endif
);
   logic [15:0] r16, g16, b16;
   logic [8:0][15:0] prod_d, prod_q;
   logic [16:0] y_d, y_q, cb_d, cb_q, cr_d, cr_q;
   logic [2:0] vs_d, vs_q, hr_d, hr_q, de_d, de_q;
   logic [7:0] y8_d, y8_q, cb8_d, cb8_q, cr8_d, cr8_q;
   // Expand to 8 bits, form products, sums and de-gated outputs
   always_comb begin
      r16 = {8'd0, img_red, img_red[4:2]};
      g16 = {8'd0, img_green, img_green[5:4]};
      b16 = {8'd0, img_blue, img_blue[4:2]};
      prod_d[0] = 16'd77 * r16;
      prod_d[1] = 16'd150 * g16;
      prod_d[2] = 16'd29 * b16;
      prod_d[3] = 16'd43 * r16;
      prod_d[4] = 16'd85 * g16;
      prod_d[5] = 16'd128 * b16;
      prod_d[6] = 16'd128 * r16;
      prod_d[7] = 16'd107 * g16;
      prod_d[8] = 16'd21 * b16;
      y_d  = {1'b0, prod_q[0]} + {1'b0, prod_q[1]} + {1'b0, prod_q[2]};
      cb_d = {1'b0, prod_q[5]} + 17'd32768 - {1'b0, prod_q[3]} - {1'b0, prod_q[4]};
      cr_d = {1'b0, prod_q[6]} + 17'd32768 - {1'b0, prod_q[7]} - {1'b0, prod_q[8]};
      y8_d  = de_q[1] ? y_q[15:8] : 8'd0;
      cb8_d = de_q[1] ? cb_q[15:8] : 8'd0;
      cr8_d = de_q[1] ? cr_q[15:8] : 8'd0;
      vs_d = {vs_q[1:0], pre_frame_vsync};
      hr_d = {hr_q[1:0], pre_frame_href};
      de_d = {de_q[1:0], pre_frame_de};
   end
   // Pipeline registers; reset flushes any in-flight pixels
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q <= '0;
         y_q    <= '0;
         cb_q   <= '0;
         cr_q   <= '0;
         y8_q   <= '0;
         cb8_q  <= '0;
         cr8_q  <= '0;
         vs_q   <= '0;
         hr_q   <= '0;
         de_q   <= '0;
      end else begin
         prod_q <= prod_d;
         y_q    <= y_d;
         cb_q   <= cb_d;
         cr_q   <= cr_d;
         y8_q   <= y8_d;
         cb8_q  <= cb8_d;
         cr8_q  <= cr8_d;
         vs_q   <= vs_d;
         hr_q   <= hr_d;
         de_q   <= de_d;
      end
   end
   assign img_y  = y8_q;
   assign img_cb = cb8_q;
   assign img_cr = cr8_q;
   assign post_frame_vsync = vs_q[2];
   assign post_frame_href  = hr_q[2];
   assign post_frame_de    = de_q[2];
`ifdef YCBCR_PIXCNT_EN
   logic [19:0] cnt_d, cnt_q, fcnt_d, fcnt_q;
   logic        pvs_d, pvs_q, rise;
   // Count output de cycles; on post vsync rise latch the old count and restart
   always_comb begin
      rise   = vs_q[2] & ~pvs_q;
      pvs_d  = vs_q[2];
      cnt_d  = rise ? {19'd0, de_q[2]} :
               (de_q[2] && cnt_q != 20'hFFFFF) ? cnt_q + 20'd1 : cnt_q;
      fcnt_d = rise ? cnt_q : fcnt_q;
   end
   // Counter state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         fcnt_q <= '0;
         pvs_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         fcnt_q <= fcnt_d;
         pvs_q  <= pvs_d;
      end
   end
   assign frame_pix_cnt = fcnt_q;
`endif
endmodule
